execute_stage: RTL
==================

Name: execute_stage

Overview:
- MIPS EX stage; drives the MEM stage through the EX/MEM pipeline register.
- Contains the ALU, the branch-target adder and the destination-register mux.
- Contains an iterative 32-cycle MULT/MULTU unit with HI/LO registers; stalls upstream stages while that unit is busy.
- All EX/MEM outputs are registered; the MEM stage consumes them directly.

Parameters:
- len, 32, datapath width
- NB, 5, register-index width
- len_mem_bus, 9, memory control bus width (passed through untouched)
- len_wb_bus, 2, writeback control bus width (passed through untouched)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_data_a  in  len  rs operand
- in_data_b  in  len  rt operand
- in_imm  in  len  sign-extended immediate
- in_shamt  in  5  shift amount
- in_pc_next  in  len  PC+4 of this instruction
- in_rt  in  NB  rt index
- in_rd  in  NB  rd index
- alu_op  in  4  ALU operation code
- alu_src  in  1  1: B operand = in_imm
- reg_dst  in  1  1: destination = rd
- in_memory_bus  in  len_mem_bus  MEM control
- in_writeBack_bus  in  len_wb_bus  WB control
- halt_flag_e  in  1  halt marker
- flush  in  1  branch-taken kill
- stall  out  1  upstream must hold inputs
- out_addr_mem  out  len  ALU result
- out_write_data  out  len  in_data_b (store data)
- out_memory_bus  out  len_mem_bus  registered MEM control
- out_writeBack_bus  out  len_wb_bus  registered WB control
- out_write_reg  out  NB  destination index
- out_zero_flag  out  1  ALU result == 0
- out_pc_branch  out  len  in_pc_next + (in_imm << 2)
- out_halt_flag  out  1  registered halt

Behaviour:
- Reset: all registered outputs 0, HI=LO=0, state IDLE, count 0, stall 0.
- B operand = alu_src ? in_imm : in_data_b.
- Destination = reg_dst ? in_rd : in_rt.
- alu_op encoding, all results mod 2^len:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed, result 0/1), 7 SLTU (unsigned, result 0/1)
  - 8 SLL, 9 SRL, 10 SRA: shift in_data_b by in_shamt
  - 11 LUI = {B[15:0], 16'h0}
  - 12 MULT, 13 MULTU: ALU result 0
  - 14 MFHI = HI, 15 MFLO = LO
- out_zero_flag = (result == 0); BEQ/BNE use SUB.
- Non-multiply instruction: one-cycle latency, EX/MEM register loads every edge.
- Multiply FSM states: IDLE, MUL.
  - IDLE with alu_op 12/13 and no flush: latch operand magnitudes (|a|, |b| for MULT; raw for MULTU), latch result sign = a[31]^b[31] (MULT only), clear 64-bit accumulator, go to MUL with count=0.
  - MUL: one shift-add step per cycle; count increments 0..31.
  - At count==31 edge: {HI,LO} = accumulator, two's-complement negated when the result sign is set; state -> IDLE.
- stall = (IDLE && multiply op) || (MUL && count != 31). A multiply asserts stall for exactly 32 cycles and retires into EX/MEM on the 33rd edge.
- While stall=1, EX/MEM loads a bubble: memory_bus=0, writeBack_bus=0, write_reg=0, halt=0; addr/data/pc_branch/zero are don't-care and are driven 0.
- MFHI/MFLO issued the cycle after a multiply retires reads the new HI/LO.
- flush=1: EX/MEM loads a bubble. If in MUL, the multiply aborts: state -> IDLE, HI/LO unchanged, stall deasserts the same cycle. Flush has priority over the multiply start.
- reset overrides flush and stall; reset mid-multiply returns to IDLE and clears HI/LO.
- Memory and writeback buses are never decoded here; they are passed through exactly.

Test Plan:
- ADD a=7, b=0xFFFFFFFF, alu_src=0 -> next edge out_addr_mem=6, zero=0; SUB 5,5 -> out_addr_mem=0, zero=1.
- SRA b=0x80000000, shamt=4 -> 0xF8000000; SLTU a=1, b=0xFFFFFFFF -> 1; SLT same operands -> 0; LUI imm=0x1234 -> 0x12340000.
- MULT a=-3, b=5 -> stall high exactly 32 cycles with bubbles out; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; following MFLO -> out_addr_mem=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- flush at count=10 of a MULT with prior HI=LO=0 -> stall drops that cycle, HI/LO stay 0, EX/MEM shows a bubble.
- in_pc_next=0x100, in_imm=0xFFFFFFFE, reg_dst=1, in_rd=9, in_memory_bus=0x1A5 -> out_pc_branch=0xF8, out_write_reg=9, out_memory_bus=0x1A5; reset -> all outputs 0.

Source files
------------

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// MIPS EX stage: ALU, branch-target adder, destination-register mux and an
// iterative shift-add MULT/MULTU unit with HI/LO registers. Every output
// towards MEM is registered in the EX/MEM pipeline register.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_data_a/in_data_b   rs / rt operands
//   in_imm, in_shamt      sign-extended immediate, shift amount
//   in_pc_next            PC+4 of the instruction in EX
//   in_rt, in_rd          candidate destination indices
//   alu_op, alu_src       ALU operation, B-operand select (1: immediate)
//   reg_dst               destination select (1: rd)
//   in_memory_bus         MEM control, passed through
//   in_writeBack_bus      WB control, passed through
//   halt_flag_e, flush    halt marker, branch-taken kill
//   stall                 upstream must hold its inputs (multiply busy)
//   out_*                 EX/MEM register contents
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int len         = 32,
    parameter int NB          = 5,
    parameter int len_mem_bus = 9,
    parameter int len_wb_bus  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [len-1:0]         in_data_a,
    input  logic [len-1:0]         in_data_b,
    input  logic [len-1:0]         in_imm,
    input  logic [4:0]             in_shamt,
    input  logic [len-1:0]         in_pc_next,
    input  logic [NB-1:0]          in_rt,
    input  logic [NB-1:0]          in_rd,
    input  logic [3:0]             alu_op,
    input  logic                   alu_src,
    input  logic                   reg_dst,
    input  logic [len_mem_bus-1:0] in_memory_bus,
    input  logic [len_wb_bus-1:0]  in_writeBack_bus,
    input  logic                   halt_flag_e,
    input  logic                   flush,
    output logic                   stall,
    output logic [len-1:0]         out_addr_mem,
    output logic [len-1:0]         out_write_data,
    output logic [len_mem_bus-1:0] out_memory_bus,
    output logic [len_wb_bus-1:0]  out_writeBack_bus,
    output logic [NB-1:0]          out_write_reg,
    output logic                   out_zero_flag,
    output logic [len-1:0]         out_pc_branch,
    output logic                   out_halt_flag
);

    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [3:0] OP_MULT  = 4'd12;
    localparam logic [3:0] OP_MULTU = 4'd13;

    // Magnitude of a two's-complement value; -2^(len-1) maps to 2^(len-1).
    function automatic logic [len-1:0] f_magnitude(input logic signed [len-1:0] v);
        return v[len-1] ? (~v + len'(1)) : v;
    endfunction

    // Re-apply the product sign to the unsigned accumulator.
    function automatic logic [2*len-1:0] f_apply_sign(input logic [2*len-1:0] mag,
                                                      input logic neg);
        return neg ? (~mag + (2*len)'(1)) : mag;
    endfunction

    state_t               r_state, w_state_next;
    logic [4:0]           r_count;
    logic [len-1:0]       r_hi, r_lo;
    logic [2*len-1:0]     r_acc, r_mcand;
    logic [len-1:0]       r_mplier;
    logic                 r_neg;

    logic [len-1:0]       w_b;
    logic signed [len-1:0] w_a_s, w_b_s, w_rt_s;
    logic [len-1:0]       w_result;
    logic [NB-1:0]        w_dest;
    logic                 w_mul_op, w_start, w_done, w_stall;
    logic [2*len-1:0]     w_acc_next;

    assign w_b      = alu_src ? in_imm : in_data_b;
    assign w_a_s    = in_data_a;
    assign w_b_s    = w_b;
    assign w_rt_s   = in_data_b;
    assign w_dest   = reg_dst ? in_rd : in_rt;
    assign w_mul_op = (alu_op == OP_MULT) || (alu_op == OP_MULTU);

    always_comb begin
        w_result = '0;
        case (alu_op)
            4'd0:    w_result = in_data_a + w_b;
            4'd1:    w_result = in_data_a - w_b;
            4'd2:    w_result = in_data_a & w_b;
            4'd3:    w_result = in_data_a | w_b;
            4'd4:    w_result = in_data_a ^ w_b;
            4'd5:    w_result = ~(in_data_a | w_b);
            4'd6:    w_result = {{(len-1){1'b0}}, (w_a_s < w_b_s)};
            4'd7:    w_result = {{(len-1){1'b0}}, (in_data_a < w_b)};
            4'd8:    w_result = in_data_b << in_shamt;
            4'd9:    w_result = in_data_b >> in_shamt;
            4'd10:   w_result = w_rt_s >>> in_shamt;
            4'd11:   w_result = {w_b[len-17:0], 16'h0000};
            4'd14:   w_result = r_hi;
            4'd15:   w_result = r_lo;
            default: w_result = '0;
        endcase
    end

    // Multiply control. Flush wins over both starting and continuing.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mul_op && !flush) begin
                    w_start      = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = MUL;
                end
            end
            MUL: begin
                if (flush) begin
                    w_state_next = IDLE;
                end else if (r_count == 5'd31) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign stall      = w_stall && !reset;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start)
                r_count <= '0;
            else if (r_state == MUL)
                r_count <= r_count + 5'd1;
            if (w_done)
                {r_hi, r_lo} <= f_apply_sign(w_acc_next, r_neg);
        end
    end

    // Shift-add datapath: multiplicand moves left, multiplier right.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_acc <= '0;
            if (alu_op == OP_MULT) begin
                r_mcand  <= {{len{1'b0}}, f_magnitude(in_data_a)};
                r_mplier <= f_magnitude(in_data_b);
                r_neg    <= in_data_a[len-1] ^ in_data_b[len-1];
            end else begin
                r_mcand  <= {{len{1'b0}}, in_data_a};
                r_mplier <= in_data_b;
                r_neg    <= 1'b0;
            end
        end else if (r_state == MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    // EX/MEM pipeline register; stall or flush inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || w_stall) begin
            out_addr_mem      <= '0;
            out_write_data    <= '0;
            out_memory_bus    <= '0;
            out_writeBack_bus <= '0;
            out_write_reg     <= '0;
            out_zero_flag     <= 1'b0;
            out_pc_branch     <= '0;
            out_halt_flag     <= 1'b0;
        end else begin
            out_addr_mem      <= w_result;
            out_write_data    <= in_data_b;
            out_memory_bus    <= in_memory_bus;
            out_writeBack_bus <= in_writeBack_bus;
            out_write_reg     <= w_dest;
            out_zero_flag     <= (w_result == '0);
            out_pc_branch     <= in_pc_next + (in_imm << 2);
            out_halt_flag     <= halt_flag_e;
        end
    end

endmodule
